fetch_queue: RTL
================

Name: fetch_queue

Overview:
- 2-wide instruction buffer between the fetch stage and the decode stage.
- Accepts up to two {instr, pc} pairs per cycle from fetch and presents the two oldest entries to decode as is_valid/instr/pc arrays, oldest in slot 0.
- Decouples fetch from dispatch stalls: dispatch reports how many decoded slots it consumed each cycle.
- Supports a single-cycle flush on branch mispredict or exception.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1 x2 (unpacked [2])  fetch slot valid; slot 0 is older.
- in_instr  input  32 x2  fetched instruction words.
- in_pc  input  32 x2  PCs of fetched instructions.
- in_ready  output  1  queue can accept a full 2-wide fetch group this cycle.
- flush  input  1  discard all entries and any same-cycle enqueue.
- deq_count  input  2  entries consumed by dispatch this cycle (0, 1 or 2).
- is_valid  output  1 x2  output slot holds a queued instruction.
- instr  output  32 x2  instruction words to decode.
- pc  output  32 x2  PCs to decode.
- count  output  $clog2(DEPTH)+1  current occupancy, for debug and perf counters.

Behaviour:
- State:
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register, $clog2(DEPTH)+1 bits.
  - storage arrays for instr and pc.
- Reset (async, immediate):
  - head = tail = count = 0.
  - Outputs: is_valid = {0,0}, instr = {0,0}, pc = {0,0}, in_ready = 1, count = 0.
  - Storage contents need not be cleared.
- in_ready is combinational from the registered count only: in_ready = (DEPTH - count >= 2). It does not depend on deq_count or flush.
- Enqueue, when in_ready = 1 and flush = 0:
  - Valid input slots are written in order, slot 0 first, starting at tail.
  - in_valid = {1,0} writes one entry.
  - in_valid = {0,1} writes one entry: slot 1 is compacted to tail.
  - in_valid = {1,1} writes two entries: slot 0 at tail, slot 1 at tail+1.
  - tail advances by the number of valid slots written.
  - When in_ready = 0, inputs are ignored; fetch must hold them.
- Output, combinational from head and count:
  - is_valid[0] = (count >= 1); is_valid[1] = (count >= 2).
  - Slot 0 reads entry head; slot 1 reads entry head+1, wrapping.
  - A slot with is_valid = 0 drives instr = 0 and pc = 0.
- Dequeue:
  - Effective dequeue = min(deq_count, count). deq_count = 3 is treated as 2, then clamped.
  - head advances by the effective dequeue.
  - Dequeue only consumes entries present at the start of the cycle. An entry enqueued in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_n - deq_eff. count never exceeds DEPTH and never underflows.
- Flush has priority over everything:
  - Next cycle: head = tail = count = 0 and is_valid = {0,0}.
  - Same-cycle enqueue and dequeue are discarded.
- Reset mid-operation: takes effect asynchronously regardless of in-flight enqueue or dequeue; behaves as a flush plus output clear.
- Wrap-around: a 2-wide write at tail = DEPTH-1 writes entries DEPTH-1 and 0. A 2-wide read at head = DEPTH-1 reads entries DEPTH-1 and 0.
- Full boundary: count = DEPTH-1 gives in_ready = 0, even if dispatch dequeues in the same cycle. One bubble is accepted for simpler timing.

Test Plan:
- Reset then idle -> is_valid = {0,0}, instr = {0,0}, in_ready = 1, count = 0 for 5 cycles.
- Enqueue {0x00100093 @pc 0x0, 0x00200113 @pc 0x4} with deq_count = 0 -> next cycle is_valid = {1,1}, instr = {0x00100093, 0x00200113}, pc = {0x0, 0x4}, count = 2.
- Enqueue in_valid = {0,1} with instr 0xDEADBEEF @pc 0x8 into an empty queue -> next cycle is_valid = {1,0}, instr[0] = 0xDEADBEEF, pc[0] = 0x8.
- Fill with 4 back-to-back pairs (pc 0x0..0x1C) at DEPTH = 8 with no dequeue -> count = 8 and in_ready = 0. Then deq_count = 1 for one cycle -> count = 7, in_ready = 0, outputs pc = {0x4, 0x8}. Then deq_count = 2 -> count = 5, in_ready = 1.
- Steady state with head at 7: enqueue 2 and dequeue 2 every cycle for 8 cycles -> count is constant, output PCs are strictly sequential across the wrap, and no entry is lost or duplicated.
- Queue holding 5 entries, flush = 1 with simultaneous in_valid = {1,1} and deq_count = 2 -> next cycle count = 0, is_valid = {0,0}, in_ready = 1. The flushed-cycle fetch group never appears on the outputs.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch/decode-side handshake bundle for the 2-wide fetch queue.
// The master modport drives fetch groups, flush and deq_count; the slave modport is the queue.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid [2];
    logic [31:0]   in_instr [2];
    logic [31:0]   in_pc    [2];
    logic          in_ready;
    logic          flush;
    logic [1:0]    deq_count;
    logic          is_valid [2];
    logic [31:0]   instr    [2];
    logic [31:0]   pc       [2];
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_instr, in_pc, flush, deq_count,
        input  in_ready, is_valid, instr, pc, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, deq_count,
        output in_ready, is_valid, instr, pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// 2-wide circular instruction buffer between fetch and decode.
// Two oldest entries are presented to decode; flush empties the queue in one cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instr_mem [DEPTH];
    logic [31:0]   r_pc_mem    [DEPTH];

    logic          w_in_ready;
    logic          w_enq_ok;
    logic [1:0]    w_enq_n;
    logic [1:0]    w_deq_req;
    logic [1:0]    w_deq_eff;
    logic [PW-1:0] w_wr_addr1;
    logic [PW-1:0] w_head1;

    // Room for a full pair is judged on the registered count only, so a full-minus-one queue stalls fetch.
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_enq_ok   = w_in_ready && !bus.flush;
    assign w_wr_addr1 = bus.in_valid[0] ? (r_tail + PW'(1)) : r_tail;
    assign w_head1    = r_head + PW'(1);

    always_comb begin
        w_enq_n   = 2'd0;
        w_deq_req = bus.deq_count;
        w_deq_eff = 2'd0;
        if (w_enq_ok) begin
            w_enq_n = 2'(bus.in_valid[0]) + 2'(bus.in_valid[1]);
        end
        if (bus.deq_count == 2'd3) begin
            w_deq_req = 2'd2;
        end
        // Request is at most 2, so a smaller count fits in its low two bits.
        if (CW'(w_deq_req) > r_count) begin
            w_deq_eff = r_count[1:0];
        end else begin
            w_deq_eff = w_deq_req;
        end
    end

    // Storage carries no reset; validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (w_enq_ok) begin
            if (bus.in_valid[0]) begin
                r_instr_mem[r_tail] <= bus.in_instr[0];
                r_pc_mem[r_tail]    <= bus.in_pc[0];
            end
            if (bus.in_valid[1]) begin
                r_instr_mem[w_wr_addr1] <= bus.in_instr[1];
                r_pc_mem[w_wr_addr1]    <= bus.in_pc[1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq_eff);
            r_tail  <= r_tail + PW'(w_enq_n);
            r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_eff);
        end
    end

    // Decode view: empty slots drive zeros so stale storage never leaks out.
    always_comb begin
        bus.in_ready    = w_in_ready;
        bus.count       = r_count;
        bus.is_valid[0] = 1'b0;
        bus.is_valid[1] = 1'b0;
        bus.instr[0]    = 32'd0;
        bus.instr[1]    = 32'd0;
        bus.pc[0]       = 32'd0;
        bus.pc[1]       = 32'd0;
        if (r_count >= CW'(1)) begin
            bus.is_valid[0] = 1'b1;
            bus.instr[0]    = r_instr_mem[r_head];
            bus.pc[0]       = r_pc_mem[r_head];
        end
        if (r_count >= CW'(2)) begin
            bus.is_valid[1] = 1'b1;
            bus.instr[1]    = r_instr_mem[w_head1];
            bus.pc[1]       = r_pc_mem[w_head1];
        end
    end
endmodule
